// File: rtl/regfile_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_scan_ctrl_pkg
// Shared definitions for the register-file scan controller: the controller
// state encoding and the default geometry and starvation constants.
// No ports (package).
// ----------------------------------------------------------------------------
package regfile_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    localparam int NREGS_DEF      = 32;
    localparam int AW_DEF         = 5;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 15;

    // Width of the starvation counter; STARVE_MAX is limited to 1..255.
    localparam int STARVE_W       = 8;

endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// regfile_scan_ctrl_if
// Bundles the scanner's external signals: the start/status pair, the shared
// register-file read port (CPU request side and address/data), and the
// valid/ready output stream to the text renderer.
//   master : the scan controller
//   slave  : the surrounding system (CPU, register file, renderer)
// ----------------------------------------------------------------------------
interface regfile_scan_ctrl_if
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          start;
    logic          busy;
    logic          done;

    logic          cpu_req;
    logic [AW-1:0] cpu_adr;
    logic          cpu_stall;
    logic [AW-1:0] rf_adr;
    logic [DW-1:0] rf_data;

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    modport master (
        input  start, cpu_req, cpu_adr, rf_data, out_ready,
        output busy, done, cpu_stall, rf_adr, out_valid, out_idx, out_data
    );

    modport slave (
        output start, cpu_req, cpu_adr, rf_data, out_ready,
        input  busy, done, cpu_stall, rf_adr, out_valid, out_idx, out_data
    );

endinterface

// File: rtl/regfile_scan_ctrl_scan_out_reg.sv
// ----------------------------------------------------------------------------
// scan_out_reg
// Valid/ready output holding register. A load captures (idx, data) and raises
// valid; the word then holds until accepted. Load has priority over the
// accept-clear so a capture in the handshake cycle hands over back-to-back.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         capture i_idx / i_data this cycle
//   i_idx, i_data  word to capture
//   i_ready        consumer accepts the current word
//   o_valid, o_idx, o_data  held output word
// ----------------------------------------------------------------------------
module scan_out_reg #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_idx,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [AW-1:0] o_idx,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_data  = r_data;

endmodule

// File: rtl/regfile_scan_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_scan_ctrl
// Register-file scan controller for the debug display. On start it reads
// registers 0..NREGS-1 through the register file's second read port, which
// it shares with the CPU, and streams (index, data) words to the renderer.
// The CPU has priority, but after STARVE_MAX denied cycles the scanner forces
// a grant (stalling the CPU for that one cycle) so a scan always completes.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus (master)  start/busy/done, CPU request + shared read port,
//                 valid/ready output stream
// ----------------------------------------------------------------------------
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    regfile_scan_ctrl_if.master bus
);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [AW-1:0]       r_scan_idx;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_done;

    logic                w_out_valid;
    logic [AW-1:0]       w_out_idx;
    logic [DW-1:0]       w_out_data;

    logic                w_handshake;
    logic                w_slot_free;
    logic                w_want;
    logic                w_force;
    logic                w_grant;
    logic                w_last;
    logic                w_done_nxt;

    // The scanner only asks for the port when its output slot can take a word.
    assign w_handshake = w_out_valid && bus.out_ready;
    assign w_slot_free = !w_out_valid || bus.out_ready;
    assign w_want      = (r_state == ST_SCAN) && w_slot_free;
    assign w_force     = w_want && bus.cpu_req &&
                         (r_starve_cnt == STARVE_W'(STARVE_MAX));
    assign w_grant     = w_want && (!bus.cpu_req || w_force);
    assign w_last      = (r_scan_idx == AW'(NREGS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_grant && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_handshake) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_idx   <= '0;
            r_starve_cnt <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_nxt;

            if (r_state == ST_IDLE && bus.start) begin
                r_scan_idx <= '0;
            end else if (w_grant && !w_last) begin
                r_scan_idx <= r_scan_idx + AW'(1);
            end

            // Counts only cycles the scanner was ready but lost to the CPU;
            // saturates so an out-of-range STARVE_MAX cannot wrap it.
            if (r_state != ST_SCAN || w_grant) begin
                r_starve_cnt <= '0;
            end else if (w_want && bus.cpu_req && !w_force &&
                         r_starve_cnt != {STARVE_W{1'b1}}) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end

    scan_out_reg #(
        .AW (AW),
        .DW (DW)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_grant),
        .i_idx   (r_scan_idx),
        .i_data  (bus.rf_data),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_idx   (w_out_idx),
        .o_data  (w_out_data)
    );

    assign bus.cpu_stall = w_force;
    assign bus.rf_adr    = w_grant ? r_scan_idx : bus.cpu_adr;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = w_out_idx;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_scan_ctrl
// Directed bench for regfile_scan_ctrl: register file model preloaded with
// x_i = 0x100 + i (x0 = 0), scenario tasks called in sequence.
// ----------------------------------------------------------------------------
module tb_regfile_scan_ctrl;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int SMAX  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_scan_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic [DW-1:0] regs [NREGS];
    assign bus.rf_data = regs[bus.rf_adr];

    regfile_scan_ctrl #(
        .NREGS      (NREGS),
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Results of the most recent run_scan.
    int   r_nwords, r_word_bad, r_stab_bad, r_grant_bad, r_adr_bad, r_gap_bad;
    int   r_ngrant, r_nstall, r_ndone, r_done_cyc;
    int   r_first_grant, r_last_grant, r_last_hs;
    logic r_busy_at_done;

    function automatic logic [DW-1:0] exp_data(input int i);
        return (i == 0) ? '0 : DW'(32'h100 + i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in the current cycle (cycle 0), then observes cycles 1..
    // until Done is seen (returns in that cycle, before the next edge).
    // ready_mode: 0 always ready, 1 pattern 1,0,0,1
    // req_mode:   0 idle CPU, 1 CPU always requesting, 2 requesting in odd cycles
    // exp_gap:    required cycles between grants (0 = not checked)
    // mid_start:  cycle in which an extra start pulse is driven (0 = none)
    task automatic run_scan(input int ready_mode, input int req_mode,
                            input int exp_gap, input int mid_start,
                            input int max_cyc);
        int            nxt_g;
        int            last_g;
        logic          pv, pr, grant_now;
        logic [AW-1:0] pidx;
        logic [DW-1:0] pdata;
        r_nwords = 0; r_word_bad = 0; r_stab_bad = 0; r_grant_bad = 0;
        r_adr_bad = 0; r_gap_bad = 0; r_ngrant = 0; r_nstall = 0;
        r_ndone = 0; r_done_cyc = -1; r_first_grant = -1; r_last_grant = -1;
        r_last_hs = -1; r_busy_at_done = 1'bx;
        bus.start     = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_adr   = AW'(16);
        bus.out_ready = 1'b1;
        pv    = bus.out_valid;
        pr    = 1'b1;
        pidx  = bus.out_idx;
        pdata = bus.out_data;
        step();
        nxt_g  = 0;
        last_g = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.start = (cyc == mid_start);
            case (req_mode)
                0:       bus.cpu_req = 1'b0;
                1:       bus.cpu_req = 1'b1;
                default: bus.cpu_req = (cyc % 2 == 1);
            endcase
            // CPU address never equals the next scan index, so seeing that
            // index on the port identifies a scanner grant.
            bus.cpu_adr   = AW'((nxt_g + 16) % NREGS);
            bus.out_ready = (ready_mode == 0) ? 1'b1
                          : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
            #2;
            grant_now = (nxt_g < NREGS) && (bus.rf_adr == AW'(nxt_g));
            if (bus.cpu_stall) r_nstall++;
            if (bus.cpu_stall && !grant_now) r_grant_bad++;
            if (grant_now && bus.cpu_req && !bus.cpu_stall) r_grant_bad++;
            if (bus.cpu_req && !bus.cpu_stall && bus.rf_adr !== bus.cpu_adr) r_adr_bad++;
            if (grant_now) begin
                if (r_ngrant == 0) r_first_grant = cyc;
                if (exp_gap > 0 && (cyc - last_g) != exp_gap) r_gap_bad++;
                last_g       = cyc;
                r_last_grant = cyc;
                r_ngrant++;
                nxt_g++;
            end
            if (pv && !pr) begin
                if (bus.out_valid !== 1'b1 || bus.out_idx !== pidx || bus.out_data !== pdata)
                    r_stab_bad++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                if (bus.out_idx !== AW'(r_nwords) || bus.out_data !== exp_data(r_nwords))
                    r_word_bad++;
                r_nwords++;
                r_last_hs = cyc;
            end
            if (bus.done === 1'b1) begin
                r_ndone++;
                r_done_cyc     = cyc;
                r_busy_at_done = bus.busy;
                break;
            end
            pv    = bus.out_valid;
            pr    = bus.out_ready;
            pidx  = bus.out_idx;
            pdata = bus.out_data;
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.cpu_req = 1'b0;
        bus.cpu_adr = AW'(7); bus.out_ready = 1'b1;
        step(); step();
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.out_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.out_idx); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall); end
        checks++; if (bus.rf_adr !== AW'(7)) begin failures++; $display("FAIL reset_rfadr got=%0d exp=7", bus.rf_adr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_best_case();
        run_scan(0, 0, 1, 0, 200);
        checks++; if (r_ndone !== 1) begin failures++; $display("FAIL best_done_seen got=%0d exp=1", r_ndone); end
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL best_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL best_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_first_grant !== 1) begin failures++; $display("FAIL best_first_grant got=%0d exp=1", r_first_grant); end
        checks++; if (r_last_grant !== NREGS) begin failures++; $display("FAIL best_last_grant got=%0d exp=%0d", r_last_grant, NREGS); end
        checks++; if (r_gap_bad !== 0) begin failures++; $display("FAIL best_gap bad=%0d exp=0", r_gap_bad); end
        checks++; if (r_last_hs !== NREGS + 1) begin failures++; $display("FAIL best_last_word_cyc got=%0d exp=%0d", r_last_hs, NREGS + 1); end
        checks++; if (r_done_cyc !== NREGS + 2) begin failures++; $display("FAIL best_done_cyc got=%0d exp=%0d", r_done_cyc, NREGS + 2); end
        checks++; if (r_busy_at_done !== 1'b0) begin failures++; $display("FAIL best_busy_at_done got=%b exp=0", r_busy_at_done); end
        step();
        #2;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL best_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL best_idle_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_ready_toggle();
        run_scan(1, 0, 0, 0, 400);
        checks++; if (r_ndone !== 1) begin failures++; $display("FAIL tog_done_seen got=%0d exp=1", r_ndone); end
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL tog_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL tog_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_stab_bad !== 0) begin failures++; $display("FAIL tog_stable bad=%0d exp=0", r_stab_bad); end
    endtask

    task automatic test_cpu_starve();
        run_scan(0, 1, SMAX + 1, 0, 700);
        checks++; if (r_ndone !== 1) begin failures++; $display("FAIL starve_done_seen got=%0d exp=1", r_ndone); end
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL starve_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL starve_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_gap_bad !== 0) begin failures++; $display("FAIL starve_gap bad=%0d exp=0", r_gap_bad); end
        checks++; if (r_nstall !== NREGS) begin failures++; $display("FAIL starve_nstall got=%0d exp=%0d", r_nstall, NREGS); end
        checks++; if (r_grant_bad !== 0) begin failures++; $display("FAIL starve_grant bad=%0d exp=0", r_grant_bad); end
        checks++; if (r_adr_bad !== 0) begin failures++; $display("FAIL starve_rfadr bad=%0d exp=0", r_adr_bad); end
        checks++; if (r_last_grant !== NREGS * (SMAX + 1)) begin failures++; $display("FAIL starve_last_grant got=%0d exp=%0d", r_last_grant, NREGS * (SMAX + 1)); end
        checks++; if (r_done_cyc !== NREGS * (SMAX + 1) + 2) begin failures++; $display("FAIL starve_done_cyc got=%0d exp=%0d", r_done_cyc, NREGS * (SMAX + 1) + 2); end
    endtask

    task automatic test_cpu_alternate();
        run_scan(0, 2, 2, 0, 200);
        checks++; if (r_ndone !== 1) begin failures++; $display("FAIL alt_done_seen got=%0d exp=1", r_ndone); end
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL alt_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL alt_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_nstall !== 0) begin failures++; $display("FAIL alt_nstall got=%0d exp=0", r_nstall); end
        checks++; if (r_grant_bad !== 0) begin failures++; $display("FAIL alt_grant bad=%0d exp=0", r_grant_bad); end
        checks++; if (r_gap_bad !== 0) begin failures++; $display("FAIL alt_gap bad=%0d exp=0", r_gap_bad); end
        checks++; if (r_last_grant !== 2 * NREGS) begin failures++; $display("FAIL alt_last_grant got=%0d exp=%0d", r_last_grant, 2 * NREGS); end
        step();
    endtask

    task automatic test_reset_mid_scan();
        bus.start = 1'b1; bus.cpu_req = 1'b0; bus.out_ready = 1'b1; bus.cpu_adr = AW'(3);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== AW'(9)) begin failures++; $display("FAIL rstmid_pre_word got=%b/%0d exp=1/9", bus.out_valid, bus.out_idx); end
        checks++; if (bus.rf_adr !== AW'(10)) begin failures++; $display("FAIL rstmid_pre_scanidx got=%0d exp=10", bus.rf_adr); end
        rst = 1'b1;
        step();
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
        checks++; if (bus.out_idx !== '0 || bus.out_data !== '0) begin failures++; $display("FAIL rstmid_word got=%0d/%h exp=0/0", bus.out_idx, bus.out_data); end
        checks++; if (bus.cpu_stall !== 1'b0 || bus.rf_adr !== AW'(3)) begin failures++; $display("FAIL rstmid_port got=%b/%0d exp=0/3", bus.cpu_stall, bus.rf_adr); end
        rst = 1'b0;
        step();
        #2;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b/%b exp=0/0", bus.done, bus.busy); end
        run_scan(0, 0, 1, 0, 200);
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL rescan_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL rescan_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_done_cyc !== NREGS + 2) begin failures++; $display("FAIL rescan_done_cyc got=%0d exp=%0d", r_done_cyc, NREGS + 2); end
        step();
    endtask

    task automatic test_back_to_back();
        // Extra start in cycle 5 falls in SCAN and must not restart the walk.
        run_scan(0, 0, 1, 5, 200);
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL ignstart_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL ignstart_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_done_cyc !== NREGS + 2) begin failures++; $display("FAIL ignstart_done_cyc got=%0d exp=%0d", r_done_cyc, NREGS + 2); end
        // Still in the Done cycle: this start must be accepted.
        run_scan(0, 0, 1, 0, 200);
        checks++; if (r_nwords !== NREGS) begin failures++; $display("FAIL b2b_nwords got=%0d exp=%0d", r_nwords, NREGS); end
        checks++; if (r_word_bad !== 0) begin failures++; $display("FAIL b2b_words bad=%0d exp=0", r_word_bad); end
        checks++; if (r_first_grant !== 1) begin failures++; $display("FAIL b2b_first_grant got=%0d exp=1", r_first_grant); end
        checks++; if (r_done_cyc !== NREGS + 2) begin failures++; $display("FAIL b2b_done_cyc got=%0d exp=%0d", r_done_cyc, NREGS + 2); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = exp_data(i);
        test_reset();
        test_best_case();
        test_ready_toggle();
        test_cpu_starve();
        test_cpu_alternate();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
